// File: rtl/pe_pkg.sv
// Shared constants for the PE_R job scheduler: scheme codes, pipeline depth, FSM encoding.
package pe_pkg;

    localparam int unsigned PIPE_NUM = 4;

    localparam logic [1:0] SCHEME0 = 2'b00;
    localparam logic [1:0] SCHEME1 = 2'b01;
    localparam logic [1:0] SCHEME2 = 2'b10;
    localparam logic [1:0] SCHEME3 = 2'b11;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd0;
    localparam logic [ST_W-1:0] ST_DRAIN = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic rr_q;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = rr_q ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (grant != 2'b00) begin
            rr_q <= grant[0];
        end
    end

endmodule

// File: rtl/pe_r_sched.sv
// Issues jobs from two requesters into the PE_R pipeline and tags the results
// that emerge PIPE_NUM cycles later; supports draining the pipeline on request.
module pe_r_sched #(
    parameter int unsigned BITWIDTH   = 18,
    parameter int unsigned CORDIC_NUM = 14,
    parameter int unsigned PIPE_NUM   = pe_pkg::PIPE_NUM,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [1:0]              req0_scheme,
    input  logic [1:0]              req0_idle,
    input  logic [CORDIC_NUM-1:0]   req0_angle0,
    input  logic [CORDIC_NUM-1:0]   req0_angle1,
    input  logic [4*BITWIDTH-1:0]   req0_data,
    input  logic [TAG_W-1:0]        req0_tag,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [1:0]              req1_scheme,
    input  logic [1:0]              req1_idle,
    input  logic [CORDIC_NUM-1:0]   req1_angle0,
    input  logic [CORDIC_NUM-1:0]   req1_angle1,
    input  logic [4*BITWIDTH-1:0]   req1_data,
    input  logic [TAG_W-1:0]        req1_tag,
    output logic [1:0]              pe_idle,
    output logic [1:0]              pe_scheme,
    output logic [CORDIC_NUM-1:0]   pe_angle0,
    output logic [CORDIC_NUM-1:0]   pe_angle1,
    output logic [4*BITWIDTH-1:0]   pe_data,
    output logic                    rsp_valid,
    output logic                    rsp_id,
    output logic [TAG_W-1:0]        rsp_tag,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [2:0]              inflight
);

    import pe_pkg::*;

    logic [ST_W-1:0]     state_q, state_d;
    logic                issue_en;
    logic [1:0]          grant;
    logic                issue;
    logic [TAG_W-1:0]    issue_tag;
    logic [PIPE_NUM-1:0] sr_valid;
    logic [PIPE_NUM-1:0] sr_id;
    logic [TAG_W-1:0]    sr_tag [PIPE_NUM];
    logic [2:0]          inflight_q, inflight_d;
    logic                drain_done_q;

    // Readiness never looks at PE_R results, so no loop through the datapath.
    assign issue_en   = rst_n && (state_q == ST_RUN) && !drain_req;
    assign issue      = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (issue_en),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    always_comb begin
        pe_idle   = 2'b11;
        pe_scheme = '0;
        pe_angle0 = '0;
        pe_angle1 = '0;
        pe_data   = '0;
        issue_tag = '0;
        if (grant[0]) begin
            pe_idle   = req0_idle;
            pe_scheme = req0_scheme;
            pe_angle0 = req0_angle0;
            pe_angle1 = req0_angle1;
            pe_data   = req0_data;
            issue_tag = req0_tag;
        end else if (grant[1]) begin
            pe_idle   = req1_idle;
            pe_scheme = req1_scheme;
            pe_angle0 = req1_angle0;
            pe_angle1 = req1_angle1;
            pe_data   = req1_data;
            issue_tag = req1_tag;
        end
    end

    // Job identity travels alongside PE_R so it lines up with its result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_valid <= '0;
            sr_id    <= '0;
            for (int i = 0; i < int'(PIPE_NUM); i++) begin
                sr_tag[i] <= '0;
            end
        end else begin
            sr_valid  <= {sr_valid[PIPE_NUM-2:0], issue};
            sr_id     <= {sr_id[PIPE_NUM-2:0], grant[1]};
            sr_tag[0] <= issue_tag;
            for (int i = 1; i < int'(PIPE_NUM); i++) begin
                sr_tag[i] <= sr_tag[i-1];
            end
        end
    end

    assign rsp_valid = sr_valid[PIPE_NUM-1];
    assign rsp_id    = sr_id[PIPE_NUM-1];
    assign rsp_tag   = sr_tag[PIPE_NUM-1];

    assign inflight_d = inflight_q + 3'(issue) - 3'(rsp_valid);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (inflight_d == 3'd0) state_d = ST_DONE;
            ST_DONE:  if (!drain_req) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            inflight_q   <= 3'd0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            drain_done_q <= (state_d == ST_DONE);
        end
    end

    assign inflight   = inflight_q;
    assign drain_done = drain_done_q;

endmodule

// File: tb/tb_pe_r_sched.sv
// Randomized and directed bench for pe_r_sched: a reference model predicts grants,
// PE_R drive and occupancy; a scoreboard checks every tagged response.
module tb_pe_r_sched;

    localparam int unsigned BW  = 18;
    localparam int unsigned CN  = 14;
    localparam int unsigned PN  = 4;
    localparam int unsigned TW  = 4;
    localparam int unsigned DW  = 4 * BW;
    localparam int P_RUN   = 0;
    localparam int P_DRAIN = 1;
    localparam int P_DONE  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [1:0]    req0_scheme = '0, req1_scheme = '0;
    logic [1:0]    req0_idle = '0, req1_idle = '0;
    logic [CN-1:0] req0_angle0 = '0, req0_angle1 = '0, req1_angle0 = '0, req1_angle1 = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic [TW-1:0] req0_tag = '0, req1_tag = '0;
    logic [1:0]    pe_idle, pe_scheme;
    logic [CN-1:0] pe_angle0, pe_angle1;
    logic [DW-1:0] pe_data;
    logic          rsp_valid, rsp_id;
    logic [TW-1:0] rsp_tag;
    logic          drain_req = 1'b0;
    logic          drain_done;
    logic [2:0]    inflight;

    pe_r_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_scheme(req0_scheme),
        .req0_idle(req0_idle), .req0_angle0(req0_angle0), .req0_angle1(req0_angle1),
        .req0_data(req0_data), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_scheme(req1_scheme),
        .req1_idle(req1_idle), .req1_angle0(req1_angle0), .req1_angle1(req1_angle1),
        .req1_data(req1_data), .req1_tag(req1_tag),
        .pe_idle(pe_idle), .pe_scheme(pe_scheme), .pe_angle0(pe_angle0),
        .pe_angle1(pe_angle1), .pe_data(pe_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .drain_req(drain_req), .drain_done(drain_done), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int tag;
        int due;
    } exp_t;

    exp_t sb[$];
    int   due_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   phase = P_RUN;
    int   m_rr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: predicts the grant and PE_R drive for the inputs currently applied.
    always @(negedge clk) begin
        int g;
        logic [1:0]    e_idle, e_scheme;
        logic [CN-1:0] e_a0, e_a1;
        logic [DW-1:0] e_data;
        int            e_tag;
        int            later[$];
        if (!rst_n) begin
            phase = P_RUN;
            m_rr  = 0;
            due_q.delete();
            sb.delete();
            chk("rst_ready0", 128'(req0_ready), 128'(0));
            chk("rst_ready1", 128'(req1_ready), 128'(0));
            chk("rst_pe_idle", 128'(pe_idle), 128'(2'b11));
            chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
            chk("rst_inflight", 128'(inflight), 128'(0));
            chk("rst_drain_done", 128'(drain_done), 128'(0));
        end else begin
            g = -1;
            if (phase == P_RUN && !drain_req) begin
                if (req0_valid && req1_valid) g = m_rr;
                else if (req0_valid) g = 0;
                else if (req1_valid) g = 1;
            end
            chk("ready0", 128'(req0_ready), 128'(g == 0));
            chk("ready1", 128'(req1_ready), 128'(g == 1));
            e_idle = 2'b11; e_scheme = '0; e_a0 = '0; e_a1 = '0; e_data = '0; e_tag = 0;
            if (g == 0) begin
                e_idle = req0_idle; e_scheme = req0_scheme; e_a0 = req0_angle0;
                e_a1 = req0_angle1; e_data = req0_data; e_tag = int'(req0_tag);
            end else if (g == 1) begin
                e_idle = req1_idle; e_scheme = req1_scheme; e_a0 = req1_angle0;
                e_a1 = req1_angle1; e_data = req1_data; e_tag = int'(req1_tag);
            end
            chk("pe_idle", 128'(pe_idle), 128'(e_idle));
            chk("pe_scheme", 128'(pe_scheme), 128'(e_scheme));
            chk("pe_angle0", 128'(pe_angle0), 128'(e_a0));
            chk("pe_angle1", 128'(pe_angle1), 128'(e_a1));
            chk("pe_data", 128'(pe_data), 128'(e_data));
            due_q = due_q.find(item) with (item >= cyc);
            chk("inflight", 128'(inflight), 128'(due_q.size()));
            chk("drain_done", 128'(drain_done), 128'(phase == P_DONE));
            if (g >= 0) begin
                due_q.push_back(cyc + int'(PN));
                sb.push_back('{id: g, tag: e_tag, due: cyc + int'(PN)});
                m_rr = 1 - g;
            end
            later = due_q.find(item) with (item > cyc);
            case (phase)
                P_RUN:   if (drain_req) phase = P_DRAIN;
                P_DRAIN: if (later.size() == 0) phase = P_DONE;
                default: if (!drain_req) phase = P_RUN;
            endcase
        end
    end

    // Scoreboard monitor: every response must match the oldest outstanding job, on time.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 128'(rsp_id), 128'(e.id));
                    chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
                    chk("rsp_cycle", 128'(cyc), 128'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("rsp_missing", 128'(0), 128'(1));
                void'(sb.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        req0_scheme = 2'($urandom); req0_idle = 2'($urandom);
        req0_angle0 = CN'($urandom); req0_angle1 = CN'($urandom);
        req0_data   = DW'({$urandom, $urandom, $urandom});
        req1_scheme = 2'($urandom); req1_idle = 2'($urandom);
        req1_angle0 = CN'($urandom); req1_angle1 = CN'($urandom);
        req1_data   = DW'({$urandom, $urandom, $urandom});
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            rand_fields();
            step();
        end
    endtask

    initial begin
        int  t0, t1;
        logic a0, a1;
        bit  seen;
        repeat (3) step();
        rst_n = 1'b1;

        // Nothing offered: PE_R held idle, no responses.
        idle_cycles(6);

        // Both requesters stream tags 0..7 each.
        t0 = 0; t1 = 0;
        for (int k = 0; k < 40 && (t0 < 8 || t1 < 8); k++) begin
            rand_fields();
            req0_valid = (t0 < 8); req0_tag = TW'(t0);
            req1_valid = (t1 < 8); req1_tag = TW'(t1);
            @(negedge clk);
            a0 = req0_ready; a1 = req1_ready;
            step();
            if (a0) t0++;
            if (a1) t1++;
        end
        chk("stream_tags_issued", 128'({t0[7:0], t1[7:0]}), 128'(16'h0808));
        idle_cycles(8);

        // Lone job from requester 1.
        rand_fields();
        req1_valid = 1'b1; req1_tag = 4'd5; req1_scheme = 2'b10;
        step();
        idle_cycles(8);

        // Four back-to-back jobs, then drain.
        for (int k = 0; k < 4; k++) begin
            rand_fields();
            req0_valid = 1'b1; req0_tag = TW'(k);
            step();
        end
        drain_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            rand_fields();
            req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            @(negedge clk);
            seen = drain_done;
            step();
        end
        chk("drain_done_reached", 128'(seen), 128'(1));
        drain_req = 1'b0;
        idle_cycles(3);

        // Saturated random traffic: issue and retire in the same cycle.
        for (int k = 0; k < 40; k++) begin
            rand_fields();
            req0_valid = ($urandom_range(0, 9) < 8); req0_tag = TW'($urandom);
            req1_valid = ($urandom_range(0, 9) < 8); req1_tag = TW'($urandom);
            step();
        end
        idle_cycles(6);

        // Reset with three jobs in flight; pointer left at requester 1 beforehand.
        for (int k = 0; k < 3; k++) begin
            rand_fields();
            req0_valid = 1'b1; req0_tag = TW'(k + 9);
            step();
        end
        req0_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        idle_cycles(8);
        rand_fields();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_tag = 4'd1; req1_tag = 4'd2;
        step();
        step();
        idle_cycles(8);

        // Random mix with drain toggling.
        for (int k = 0; k < 300; k++) begin
            rand_fields();
            req0_valid = 1'($urandom); req0_tag = TW'($urandom);
            req1_valid = 1'($urandom); req1_tag = TW'($urandom);
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            step();
        end
        drain_req = 1'b0;
        idle_cycles(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_r_sched.md
PE_R_SCHED -- requirements
Module: pe_r_sched

Interface
REQ-001 Parameters SHALL be: BITWIDTH, 18, sample width; CORDIC_NUM, 14, micro-rotation count (angle-word width); PIPE_NUM, 4, PE_R latency in cycles; TAG_W, 4, job tag width.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
 clk  in  1  clock; rising edge.
 rst_n  in  1  reset, asynchronous, active-low.
 reqN_valid  in  1  job offered by requester N (N=0,1).
 reqN_ready  out  1  job from requester N accepted this cycle.
 reqN_scheme  in  2  PE_R scheme code.
 reqN_idle  in  2  per-CORDIC idle mask (bit0 CORDIC0, bit1 CORDIC1).
 reqN_angle0, reqN_angle1  in  CORDIC_NUM  direction words for CORDIC0 and CORDIC1.
 reqN_data  in  4*BITWIDTH  {Y1,X1,Y0,X0} operands.
 reqN_tag  in  TAG_W  requester-local job id.
 pe_idle  out  2  to PE_R idle.
 pe_scheme  out  2  to PE_R scheme.
 pe_angle0, pe_angle1  out  CORDIC_NUM  to PE_R angle_d0_i, angle_d1_i.
 pe_data  out  4*BITWIDTH  to PE_R X0_i/Y0_i/X1_i/Y1_i.
 rsp_valid  out  1  PE_R outputs hold a job result this cycle.
 rsp_id  out  1  requester owning the result.
 rsp_tag  out  TAG_W  tag of the result.
 drain_req  in  1  stop issuing and empty the pipeline.
 drain_done  out  1  drain complete, pipeline empty.
 inflight  out  3  jobs currently in the PE_R pipeline (0..PIPE_NUM).

Function
REQ-003 An issue SHALL occur in a cycle where state is RUN and at least one reqN_valid is high; exactly one reqN_ready SHALL be high in that cycle, and that job is accepted at the rising edge.
REQ-004 Arbitration SHALL be round-robin: pointer rr (reset 0) marks the preferred requester; if both are valid, the preferred one wins; after each issue rr SHALL point at the requester that did not win.
REQ-005 A single valid requester SHALL be granted in the same cycle regardless of rr.
REQ-006 In an issue cycle, pe_* SHALL combinationally equal the granted request's fields; in all other cycles pe_idle=2'b11 and pe_scheme, pe_angle0, pe_angle1, pe_data=0.
REQ-007 reqN_ready SHALL depend only on state, rr and reqN_valid, never on PE_R outputs, so no combinational loop exists.
REQ-008 A job issued in cycle t SHALL produce rsp_valid=1 in cycle t+PIPE_NUM, with the rsp_id and rsp_tag of that job, aligned with PE_R outputs; a PIPE_NUM-deep valid/id/tag shift register implements this.
REQ-009 The response path SHALL have no backpressure; the sink must accept every rsp_valid cycle.
REQ-010 Back-to-back issues SHALL be supported every cycle; throughput is one job per cycle.
REQ-011 inflight SHALL increment on issue, decrement on rsp_valid, and stay unchanged when both occur in the same cycle; the range is 0..PIPE_NUM.
REQ-012 The FSM SHALL have states RUN, DRAIN and DONE; it resets to RUN.
REQ-013 RUN->DRAIN SHALL occur when drain_req=1; no issue occurs in the cycle drain_req is first seen.
REQ-014 DRAIN->DONE SHALL occur when inflight=0 and no rsp_valid is pending; DRAIN with inflight already 0 SHALL reach DONE in one cycle.
REQ-015 drain_done SHALL be 1 only in DONE.
REQ-016 DONE->RUN SHALL occur when drain_req=0.
REQ-017 In DRAIN and DONE, both reqN_ready SHALL be 0 and responses SHALL continue to emerge.

Reset
REQ-018 Asserting rst_n low SHALL asynchronously clear: state=RUN, rr=0, shift register, rsp_valid=0, rsp_id=0, rsp_tag=0, inflight=0, drain_done=0.
REQ-019 Jobs in flight at reset SHALL be discarded, with no rsp_valid for them after reset release.
REQ-020 While rst_n=0, reqN_ready SHALL be 0 and pe_idle SHALL be 2'b11.

Structure
REQ-021 Scheme codes (SCHEME0..3), PIPE_NUM and the FSM state encoding SHALL be defined in shared package pe_pkg.
REQ-022 One sub-module, rr_arb2 (2-way round-robin arbiter with grant and pointer update), SHALL be instantiated.
REQ-023 PE_R SHALL NOT be instantiated inside this block; the block is integrated with PE_R at the next level up.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
 Both valid continuously, tags 0..7 each -> grants alternate 0,1,0,1..., rsp_valid continuous from cycle 4, ids alternating, tags in order.
 Only req1_valid, single job tag=5, scheme=2'b10 -> pe_scheme=2'b10 in issue cycle t; rsp_valid, rsp_id=1, rsp_tag=5 at t+4 only.
 4 back-to-back issues, then drain_req=1 -> inflight reaches 4, ready=0, drain_done=1 one cycle after the last rsp_valid.
 Issue and response in the same cycle at steady state -> inflight holds 4.
 rst_n pulsed low with 3 jobs in flight -> no rsp_valid afterwards; inflight=0, rr=0.
 No valid requests -> pe_idle=2'b11, pe_data=0, rsp_valid stays 0.
